// File: rtl/fetch_seq_32.sv
// fetch_seq_32: instruction fetch/sequencing FSM. It fetches one word from
// instruction memory, strobes the control decoder, waits for the decode to
// finish (with a timeout), then advances pc by +4, by a taken branch or by a jump.
// HALT is sticky and only reset leaves it.
module fetch_seq_32 #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          TIMEOUT  = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        run,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr,
  output logic [5:0]  opcode,
  output logic        start,
  input  logic        finish,
  input  logic        err_illegal_opcode,
  input  logic        branch,
  input  logic        jump,
  input  logic        alu_zero,
  output logic [31:0] pc,
  output logic        retire,
  output logic        halted,
  output logic        err_timeout
);

  localparam int CW = $clog2(TIMEOUT) + 1;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    START,
    WAIT_FIN,
    UPDATE,
    HALT
  } state_t;

  state_t        state;
  state_t        next_state;
  logic [CW-1:0] wait_cnt;
  logic          set_timeout;
  logic [31:0]   p4;
  logic [31:0]   branch_target;
  logic [31:0]   jump_target;
  logic [31:0]   next_pc;

  // Strobes and requests decode directly from the state, so each is high only in its own state.
  assign imem_req  = (state == FETCH);
  assign start     = (state == START);
  assign retire    = (state == UPDATE);
  assign halted    = (state == HALT);
  assign imem_addr = pc;
  assign opcode    = instr[31:26];

  // Next-pc candidates. Jump takes priority over a taken branch; all arithmetic wraps at 2^32.
  assign p4            = pc + 32'd4;
  assign branch_target = p4 + {{14{instr[15]}}, instr[15:0], 2'b00};
  assign jump_target   = {p4[31:28], instr[25:0], 2'b00};

  // Select the next pc from the decoder's jump/branch outputs and the ALU zero flag.
  always_comb begin
    next_pc = p4;
    if (jump) begin
      next_pc = jump_target;
    end else if (branch && alu_zero) begin
      next_pc = branch_target;
    end
  end

  // Next-state logic: finish with illegal opcode beats plain finish, which beats the timeout.
  always_comb begin
    next_state  = state;
    set_timeout = 1'b0;
    case (state)
      IDLE: begin
        if (run) next_state = FETCH;
      end
      FETCH: begin
        if (imem_ack) next_state = START;
      end
      START: begin
        next_state = WAIT_FIN;
      end
      WAIT_FIN: begin
        if (finish && err_illegal_opcode) begin
          next_state = HALT;
        end else if (finish) begin
          next_state = UPDATE;
        end else if (wait_cnt == CW'(TIMEOUT - 1)) begin
          next_state  = HALT;
          set_timeout = 1'b1;
        end
      end
      UPDATE: begin
        next_state = IDLE;
      end
      HALT: begin
        next_state = HALT;
      end
      default: begin
        next_state = IDLE;
      end
    endcase
  end

  // State, pc, instruction latch, wait counter and sticky timeout flag, with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      pc          <= RESET_PC;
      instr       <= 32'd0;
      wait_cnt    <= '0;
      err_timeout <= 1'b0;
    end else begin
      state <= next_state;
      if (state == FETCH && imem_ack) begin
        instr <= imem_rdata;
      end
      if (state == START) begin
        wait_cnt <= '0;
      end else if (state == WAIT_FIN) begin
        wait_cnt <= wait_cnt + CW'(1);
      end
      if (state == UPDATE) begin
        pc <= next_pc;
      end
      if (set_timeout) begin
        err_timeout <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_fetch_seq_32.sv
// tb_fetch_seq_32: directed and randomized instruction sequences for fetch_seq_32,
// checked against a behavioural model of pc sequencing and FSM phase timing.
module tb_fetch_seq_32;

  localparam logic [31:0] RST_PC = 32'hFFFF_FFFC;
  localparam int          TMO    = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic        run;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] instr;
  logic [5:0]  opcode;
  logic        start;
  logic        finish;
  logic        err_illegal_opcode;
  logic        branch;
  logic        jump;
  logic        alu_zero;
  logic [31:0] pc;
  logic        retire;
  logic        halted;
  logic        err_timeout;

  int          checks = 0;
  int          passes = 0;
  logic [31:0] m_pc;
  logic [31:0] m_instr;

  fetch_seq_32 #(.RESET_PC(RST_PC), .TIMEOUT(TMO)) dut (
    .clk(clk),
    .rst(rst),
    .run(run),
    .imem_req(imem_req),
    .imem_addr(imem_addr),
    .imem_ack(imem_ack),
    .imem_rdata(imem_rdata),
    .instr(instr),
    .opcode(opcode),
    .start(start),
    .finish(finish),
    .err_illegal_opcode(err_illegal_opcode),
    .branch(branch),
    .jump(jump),
    .alu_zero(alu_zero),
    .pc(pc),
    .retire(retire),
    .halted(halted),
    .err_timeout(err_timeout)
  );

  // Free-running clock, 10 time units per cycle.
  always #5 clk = ~clk;

  // Advance one clock and settle just after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Count one comparison and report it when observed and expected differ.
  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got === exp) begin
      passes++;
    end else begin
      $display("[TB] FAIL %s: got %08h expected %08h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference next-pc rule expressed with plain integer arithmetic.
  function automatic logic [31:0] model_next(input logic [31:0] cur, input logic [31:0] ins,
                                             input logic br, input logic jp, input logic zr);
    logic [31:0] p4;
    logic [15:0] imm;
    longint      off;
    p4 = cur + 32'd4;
    if (jp) return (p4 & 32'hF000_0000) | ((ins & 32'h03FF_FFFF) * 32'd4);
    if (br && zr) begin
      imm = ins[15:0];
      off = longint'($signed(imm)) * 4;
      return 32'(longint'(p4) + off);
    end
    return p4;
  endfunction

  // Apply reset with noisy inputs and check every reset value.
  task automatic do_reset();
    rst        = 1'b1;
    run        = 1'($urandom);
    imem_ack   = 1'($urandom);
    imem_rdata = $urandom;
    finish     = 1'($urandom);
    tick();
    rst      = 1'b0;
    run      = 1'b0;
    imem_ack = 1'b0;
    finish   = 1'b0;
    m_pc     = RST_PC;
    m_instr  = 32'd0;
    checkOutput("rst_pc", pc, RST_PC);
    checkOutput("rst_instr", instr, 32'd0);
    checkOutput("rst_req", 32'(imem_req), 32'd0);
    checkOutput("rst_start", 32'(start), 32'd0);
    checkOutput("rst_retire", 32'(retire), 32'd0);
    checkOutput("rst_halted", 32'(halted), 32'd0);
    checkOutput("rst_tmo", 32'(err_timeout), 32'd0);
  endtask

  // Run one instruction from IDLE: ack after ack_dly FETCH cycles, finish on
  // WAIT_FIN cycle fin_dly (>= TMO means never), then the decoder outcome.
  task automatic applyStimulus(input logic [31:0] word, input int ack_dly, input int fin_dly,
                               input logic ill, input logic br, input logic jp, input logic zr);
    bit done;
    done = 0;
    checkOutput("idle_req", 32'(imem_req), 32'd0);
    checkOutput("idle_pc", pc, m_pc);
    checkOutput("idle_instr", instr, m_instr);
    run = 1'b1;
    tick();
    for (int i = 0; i <= ack_dly; i++) begin
      checkOutput("fetch_req", 32'(imem_req), 32'd1);
      checkOutput("fetch_addr", imem_addr, m_pc);
      checkOutput("fetch_start", 32'(start), 32'd0);
      run        = 1'($urandom);
      imem_ack   = (i == ack_dly);
      imem_rdata = (i == ack_dly) ? word : $urandom;
      finish     = 1'($urandom);
      tick();
    end
    m_instr = word;
    checkOutput("start_pulse", 32'(start), 32'd1);
    checkOutput("start_req", 32'(imem_req), 32'd0);
    checkOutput("start_instr", instr, word);
    checkOutput("start_opcode", 32'(opcode), 32'(word[31:26]));
    imem_ack   = 1'($urandom);
    imem_rdata = $urandom;
    finish     = 1'($urandom);
    tick();
    for (int k = 0; k < TMO; k++) begin
      checkOutput("wait_start", 32'(start), 32'd0);
      checkOutput("wait_halted", 32'(halted), 32'd0);
      checkOutput("wait_retire", 32'(retire), 32'd0);
      run                = 1'($urandom);
      imem_ack           = 1'($urandom);
      finish             = (k == fin_dly);
      err_illegal_opcode = (k == fin_dly) ? ill : 1'($urandom);
      tick();
      if (k == fin_dly) begin
        done = 1;
        break;
      end
    end
    finish             = 1'b0;
    err_illegal_opcode = 1'b0;
    imem_ack           = 1'b0;
    if (!done || ill) begin
      checkOutput("halt_halted", 32'(halted), 32'd1);
      checkOutput("halt_tmo", 32'(err_timeout), done ? 32'd0 : 32'd1);
      checkOutput("halt_retire", 32'(retire), 32'd0);
      checkOutput("halt_pc", pc, m_pc);
      run = 1'b1;
      for (int j = 0; j < 4; j++) begin
        finish   = 1'($urandom);
        imem_ack = 1'($urandom);
        tick();
        checkOutput("halt_stay", 32'(halted), 32'd1);
        checkOutput("halt_req", 32'(imem_req | start | retire), 32'd0);
        checkOutput("halt_pc_hold", pc, m_pc);
      end
      run      = 1'b0;
      finish   = 1'b0;
      imem_ack = 1'b0;
    end else begin
      checkOutput("upd_retire", 32'(retire), 32'd1);
      checkOutput("upd_pc_old", pc, m_pc);
      branch   = br;
      jump     = jp;
      alu_zero = zr;
      run      = 1'b0;
      tick();
      m_pc     = model_next(m_pc, m_instr, br, jp, zr);
      branch   = 1'($urandom);
      jump     = 1'($urandom);
      alu_zero = 1'($urandom);
      checkOutput("next_pc", pc, m_pc);
      checkOutput("idle_retire", 32'(retire), 32'd0);
      tick();
      checkOutput("idle_stay", 32'(imem_req), 32'd0);
      checkOutput("idle_pc_hold", pc, m_pc);
      branch   = 1'b0;
      jump     = 1'b0;
      alu_zero = 1'b0;
    end
  endtask

  // Directed cases first, then randomized instructions, then halt and reset paths.
  initial begin
    rst = 1'b1; run = 1'b0; imem_ack = 1'b0; imem_rdata = 32'd0; finish = 1'b0;
    err_illegal_opcode = 1'b0; branch = 1'b0; jump = 1'b0; alu_zero = 1'b0;
    m_pc = RST_PC; m_instr = 32'd0;
    tick();
    do_reset();

    applyStimulus(32'h0000_0020, 2, 0, 1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("wrap_to_0", pc, 32'd0);
    applyStimulus(32'h0000_0020, 2, 0, 1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("rtype_0_to_4", pc, 32'd4);
    applyStimulus(32'h0000_0020, 0, 15, 1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("late_finish_pc8", pc, 32'd8);
    applyStimulus(32'h1000_FFFE, 1, 1, 1'b0, 1'b1, 1'b0, 1'b1);
    checkOutput("beq_taken", pc, 32'd4);
    applyStimulus(32'h1000_FFFE, 0, 2, 1'b0, 1'b1, 1'b0, 1'b0);
    checkOutput("beq_not_taken", pc, 32'd8);
    applyStimulus(32'h0BFF_FFFF, 0, 0, 1'b0, 1'b0, 1'b1, 1'b0);
    checkOutput("jump_far", pc, 32'h0FFF_FFFC);
    applyStimulus(32'h0000_0020, 1, 0, 1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("pc_1000_0000", pc, 32'h1000_0000);
    applyStimulus(32'h0800_0010, 0, 0, 1'b0, 1'b1, 1'b1, 1'b1);
    checkOutput("jump_priority", pc, 32'h1000_0040);

    for (int n = 0; n < 40; n++) begin
      applyStimulus($urandom, int'($urandom_range(0, 3)), int'($urandom_range(0, 5)), 1'b0,
                    1'($urandom), 1'($urandom), 1'($urandom));
    end

    applyStimulus(32'h0000_0020, 1, 100, 1'b0, 1'b0, 1'b0, 1'b0);
    do_reset();

    applyStimulus(32'h0000_0020, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0);
    applyStimulus(32'hFC00_0000, 1, 2, 1'b1, 1'b0, 1'b0, 1'b0);
    do_reset();

    run = 1'b1;
    tick();
    run = 1'b0;
    checkOutput("mid_fetch_req", 32'(imem_req), 32'd1);
    rst        = 1'b1;
    imem_ack   = 1'b1;
    imem_rdata = 32'hDEAD_BEEF;
    tick();
    rst      = 1'b0;
    imem_ack = 1'b0;
    checkOutput("mid_rst_req", 32'(imem_req), 32'd0);
    checkOutput("mid_rst_instr", instr, 32'd0);
    checkOutput("mid_rst_pc", pc, RST_PC);
    tick();
    checkOutput("mid_rst_idle", 32'(imem_req), 32'd0);
    applyStimulus(32'h0000_0020, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("after_rst_wrap", pc, 32'd0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
